ysyx_23060124_axi_rd_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite read-channel arbiter (AR/R only).
- Lets the IFU instruction fetch and the EXU/LSU load path share a single memory read port.
- Sits between those masters and the SRAM/crossbar slave.
- Allows one outstanding transaction total.
- Grants round-robin when both masters request at once.
- LSU write channels (AW/W/B) bypass this block.

---
 rtl/ysyx_23060124_axi_rd_arbiter_if.sv | 19 +
 rtl/ysyx_23060124_axi_rd_arbiter.sv | 92 +++++++++
 tb/tb_ysyx_23060124_axi_rd_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060124_axi_rd_arbiter_if.sv
// AXI4-Lite read channel (AR/R) bundle. "master" drives AR and rready;
// "slave" answers with arready and the R beat.
interface ysyx_23060124_axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (output araddr, arvalid, rready,
                  input  arready, rdata, rresp, rvalid);
  modport slave  (input  araddr, arvalid, rready,
                  output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/ysyx_23060124_axi_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4-Lite read arbiter, one outstanding
// transaction, round-robin on ties. Write channels do not pass through here.
module ysyx_23060124_axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 i_rst,
  ysyx_23060124_axi_rd_arbiter_if.slave        ifu,
  ysyx_23060124_axi_rd_arbiter_if.slave        lsu,
  ysyx_23060124_axi_rd_arbiter_if.master       mem,
  output logic                                 o_grant
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  sel_lsu;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // LSU wins only if it is alone or the IFU was served last.
  assign sel_lsu = lsu.arvalid && (!ifu.arvalid || !last_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    grant_d     = grant_q;
    last_d      = last_q;
    ifu.arready = 1'b0;
    lsu.arready = 1'b0;
    ifu.rvalid  = 1'b0;
    lsu.rvalid  = 1'b0;
    mem.arvalid = 1'b0;
    mem.araddr  = addr_q;
    mem.rready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_lsu) begin
          lsu.arready = 1'b1;
          addr_d      = lsu.araddr;
          grant_d     = 1'b1;
          state_d     = ADDR;
        end else if (ifu.arvalid) begin
          ifu.arready = 1'b1;
          addr_d      = ifu.araddr;
          grant_d     = 1'b0;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        mem.arvalid = 1'b1;
        if (mem.arready) state_d = DATA;
      end
      DATA: begin
        if (grant_q) begin
          lsu.rvalid = mem.rvalid;
          mem.rready = lsu.rready;
        end else begin
          ifu.rvalid = mem.rvalid;
          mem.rready = ifu.rready;
        end
        if (mem.rvalid && mem.rready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // R payload is broadcast; only the owner sees rvalid.
  assign ifu.rdata = mem.rdata[DATA_WIDTH-1:0];
  assign lsu.rdata = mem.rdata[DATA_WIDTH-1:0];
  assign ifu.rresp = mem.rresp;
  assign lsu.rresp = mem.rresp;
  assign o_grant   = grant_q;
endmodule

// File: tb/tb_ysyx_23060124_axi_rd_arbiter.sv
// Directed bench for the IFU/LSU read arbiter: inputs change on the falling
// edge, outputs are checked 1ns later.
module tb_ysyx_23060124_axi_rd_arbiter;
  logic clk = 1'b0;
  logic i_rst;
  logic o_grant;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060124_axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifu_if ();
  ysyx_23060124_axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) lsu_if ();
  ysyx_23060124_axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

  ysyx_23060124_axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .ifu     (ifu_if),
    .lsu     (lsu_if),
    .mem     (s_if),
    .o_grant (o_grant)
  );

  task test_reset;
    i_rst = 1'b1;
    ifu_if.araddr = '0; ifu_if.arvalid = 1'b0; ifu_if.rready = 1'b0;
    lsu_if.araddr = '0; lsu_if.arvalid = 1'b0; lsu_if.rready = 1'b0;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = 32'hcafe_f00d; s_if.rresp = 2'd3;
    @(negedge clk); @(negedge clk); #1;
    total++; if (s_if.arvalid !== 1'b0) begin bad++; $display("FAIL rst_s_arvalid got=%b exp=0", s_if.arvalid); end
    total++; if (s_if.rready !== 1'b0) begin bad++; $display("FAIL rst_s_rready got=%b exp=0", s_if.rready); end
    total++; if ({ifu_if.arready, lsu_if.arready, ifu_if.rvalid, lsu_if.rvalid} !== 4'b0) begin bad++; $display("FAIL rst_master_hs got=%b exp=0000", {ifu_if.arready, lsu_if.arready, ifu_if.rvalid, lsu_if.rvalid}); end
    total++; if (o_grant !== 1'b0) begin bad++; $display("FAIL rst_grant got=%b exp=0", o_grant); end
    total++; if (s_if.araddr !== 32'h0) begin bad++; $display("FAIL rst_s_araddr got=%h exp=0", s_if.araddr); end
    total++; if (ifu_if.rdata !== 32'hcafe_f00d || lsu_if.rresp !== 2'd3) begin bad++; $display("FAIL rst_passthru got=%h/%0d exp=cafef00d/3", ifu_if.rdata, lsu_if.rresp); end
    i_rst = 1'b0; s_if.rresp = 2'd0;
  endtask

  task test_ifu_only;
    @(negedge clk); ifu_if.araddr = 32'h8000_0000; ifu_if.arvalid = 1'b1; s_if.arready = 1'b1; #1;
    total++; if (ifu_if.arready !== 1'b1) begin bad++; $display("FAIL t1_ifu_arready got=%b exp=1", ifu_if.arready); end
    total++; if (lsu_if.arready !== 1'b0) begin bad++; $display("FAIL t1_lsu_arready got=%b exp=0", lsu_if.arready); end
    total++; if (s_if.arvalid !== 1'b0) begin bad++; $display("FAIL t1_c0_s_arvalid got=%b exp=0", s_if.arvalid); end
    @(negedge clk); ifu_if.arvalid = 1'b0; ifu_if.araddr = '0; #1;
    total++; if (s_if.arvalid !== 1'b1) begin bad++; $display("FAIL t1_c1_s_arvalid got=%b exp=1", s_if.arvalid); end
    total++; if (s_if.araddr !== 32'h8000_0000) begin bad++; $display("FAIL t1_c1_s_araddr got=%h exp=80000000", s_if.araddr); end
    @(negedge clk); s_if.rvalid = 1'b1; s_if.rdata = 32'h0000_0413; ifu_if.rready = 1'b1; #1;
    total++; if (ifu_if.rvalid !== 1'b1) begin bad++; $display("FAIL t1_c2_ifu_rvalid got=%b exp=1", ifu_if.rvalid); end
    total++; if (ifu_if.rdata !== 32'h0000_0413) begin bad++; $display("FAIL t1_c2_rdata got=%h exp=00000413", ifu_if.rdata); end
    total++; if (lsu_if.rvalid !== 1'b0) begin bad++; $display("FAIL t1_c2_lsu_rvalid got=%b exp=0", lsu_if.rvalid); end
    total++; if (s_if.rready !== 1'b1) begin bad++; $display("FAIL t1_c2_s_rready got=%b exp=1", s_if.rready); end
    @(negedge clk); s_if.rvalid = 1'b0; #1;
    total++; if (s_if.arvalid !== 1'b0 || s_if.rready !== 1'b0) begin bad++; $display("FAIL t1_c3_idle got=%b%b exp=00", s_if.arvalid, s_if.rready); end
  endtask

  task test_tie;
    logic       exp_g;
    logic [31:0] exp_a;
    @(negedge clk); i_rst = 1'b1;
    @(negedge clk); i_rst = 1'b0;
    ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h8000_0004;
    lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'ha000_0048;
    s_if.arready = 1'b1; s_if.rvalid = 1'b1; ifu_if.rready = 1'b1; lsu_if.rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_g = (k == 1);
      exp_a = exp_g ? 32'ha000_0048 : 32'h8000_0004;
      if (k != 0) @(negedge clk);
      #1;
      total++; if ({ifu_if.arready, lsu_if.arready} !== {~exp_g, exp_g}) begin bad++; $display("FAIL t2_arready%0d got=%b%b exp=%b%b", k, ifu_if.arready, lsu_if.arready, ~exp_g, exp_g); end
      @(negedge clk); #1;
      total++; if (o_grant !== exp_g) begin bad++; $display("FAIL t2_grant%0d got=%b exp=%b", k, o_grant, exp_g); end
      total++; if (s_if.araddr !== exp_a) begin bad++; $display("FAIL t2_araddr%0d got=%h exp=%h", k, s_if.araddr, exp_a); end
      @(negedge clk); #1;
      total++; if ({ifu_if.rvalid, lsu_if.rvalid} !== {~exp_g, exp_g}) begin bad++; $display("FAIL t2_rvalid%0d got=%b%b exp=%b%b", k, ifu_if.rvalid, lsu_if.rvalid, ~exp_g, exp_g); end
    end
    @(negedge clk); ifu_if.arvalid = 1'b0; lsu_if.arvalid = 1'b0; s_if.rvalid = 1'b0;
  endtask

  task test_back_to_back;
    @(negedge clk); lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h8000_1000; s_if.arready = 1'b1; s_if.rvalid = 1'b1; #1;
    total++; if (lsu_if.arready !== 1'b1) begin bad++; $display("FAIL t3_accept0 got=%b exp=1", lsu_if.arready); end
    @(negedge clk); lsu_if.araddr = 32'h8000_1004; #1;
    total++; if (s_if.araddr !== 32'h8000_1000) begin bad++; $display("FAIL t3_araddr0 got=%h exp=80001000", s_if.araddr); end
    total++; if (o_grant !== 1'b1) begin bad++; $display("FAIL t3_grant got=%b exp=1", o_grant); end
    @(negedge clk); #1;
    total++; if (lsu_if.rvalid !== 1'b1) begin bad++; $display("FAIL t3_rvalid0 got=%b exp=1", lsu_if.rvalid); end
    @(negedge clk); #1;
    total++; if (lsu_if.arready !== 1'b1) begin bad++; $display("FAIL t3_accept1 got=%b exp=1", lsu_if.arready); end
    @(negedge clk); lsu_if.arvalid = 1'b0; #1;
    total++; if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h8000_1004) begin bad++; $display("FAIL t3_araddr1 got=%b/%h exp=1/80001004", s_if.arvalid, s_if.araddr); end
    @(negedge clk); #1;
    total++; if (lsu_if.rvalid !== 1'b1) begin bad++; $display("FAIL t3_rvalid1 got=%b exp=1", lsu_if.rvalid); end
    @(negedge clk); s_if.rvalid = 1'b0; s_if.arready = 1'b0; #1;
    total++; if (s_if.arvalid !== 1'b0) begin bad++; $display("FAIL t3_idle got=%b exp=0", s_if.arvalid); end
  endtask

  task test_stall;
    @(negedge clk); lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h8000_2000; #1;
    total++; if (lsu_if.arready !== 1'b1) begin bad++; $display("FAIL t4_accept got=%b exp=1", lsu_if.arready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); lsu_if.arvalid = 1'b0; lsu_if.araddr = '0; #1;
      total++; if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h8000_2000) begin bad++; $display("FAIL t4_hold%0d got=%b/%h exp=1/80002000", k, s_if.arvalid, s_if.araddr); end
    end
    @(negedge clk); s_if.arready = 1'b1; #1;
    total++; if (s_if.arvalid !== 1'b1) begin bad++; $display("FAIL t4_arvalid_at_ready got=%b exp=1", s_if.arvalid); end
    @(negedge clk); s_if.arready = 1'b0; s_if.rvalid = 1'b1; s_if.rdata = 32'h0000_55aa; lsu_if.rready = 1'b0;
    ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h8000_0000; #1;
    total++; if (lsu_if.rvalid !== 1'b1 || s_if.rready !== 1'b0) begin bad++; $display("FAIL t4_stall0 got=%b%b exp=10", lsu_if.rvalid, s_if.rready); end
    total++; if (ifu_if.arready !== 1'b0 || ifu_if.rvalid !== 1'b0) begin bad++; $display("FAIL t4_ifu_blocked got=%b%b exp=00", ifu_if.arready, ifu_if.rvalid); end
    @(negedge clk); #1;
    total++; if (lsu_if.rvalid !== 1'b1 || s_if.rready !== 1'b0) begin bad++; $display("FAIL t4_stall1 got=%b%b exp=10", lsu_if.rvalid, s_if.rready); end
    @(negedge clk); lsu_if.rready = 1'b1; #1;
    total++; if (s_if.rready !== 1'b1 || lsu_if.rdata !== 32'h0000_55aa) begin bad++; $display("FAIL t4_release got=%b/%h exp=1/000055aa", s_if.rready, lsu_if.rdata); end
  endtask

  task test_addr_hold;
    @(negedge clk); s_if.rvalid = 1'b0; #1;
    total++; if (ifu_if.arready !== 1'b1) begin bad++; $display("FAIL t5_back_to_idle got=%b exp=1", ifu_if.arready); end
    @(negedge clk); ifu_if.araddr = 32'hdead_beef; #1;
    total++; if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h8000_0000) begin bad++; $display("FAIL t5_hold0 got=%b/%h exp=1/80000000", s_if.arvalid, s_if.araddr); end
    @(negedge clk); s_if.arready = 1'b1; #1;
    total++; if (s_if.araddr !== 32'h8000_0000) begin bad++; $display("FAIL t5_hold1 got=%h exp=80000000", s_if.araddr); end
    @(negedge clk); s_if.arready = 1'b0; s_if.rvalid = 1'b1; s_if.rresp = 2'd2; ifu_if.rready = 1'b1; ifu_if.arvalid = 1'b0; #1;
    total++; if (ifu_if.rvalid !== 1'b1 || ifu_if.rresp !== 2'd2) begin bad++; $display("FAIL t5_slverr got=%b/%0d exp=1/2", ifu_if.rvalid, ifu_if.rresp); end
    total++; if (o_grant !== 1'b0) begin bad++; $display("FAIL t5_grant got=%b exp=0", o_grant); end
    @(negedge clk); s_if.rvalid = 1'b0; s_if.rresp = 2'd0; #1;
    total++; if (s_if.arvalid !== 1'b0 || ifu_if.rvalid !== 1'b0) begin bad++; $display("FAIL t5_idle got=%b%b exp=00", s_if.arvalid, ifu_if.rvalid); end
  endtask

  task test_reset_mid;
    @(negedge clk); lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h8000_3000; s_if.arready = 1'b1; #1;
    total++; if (lsu_if.arready !== 1'b1) begin bad++; $display("FAIL t6_accept got=%b exp=1", lsu_if.arready); end
    @(negedge clk); lsu_if.arvalid = 1'b0; #1;
    total++; if (s_if.arvalid !== 1'b1) begin bad++; $display("FAIL t6_addr got=%b exp=1", s_if.arvalid); end
    @(negedge clk); s_if.arready = 1'b0; lsu_if.rready = 1'b1; #1;
    total++; if (o_grant !== 1'b1 || s_if.rready !== 1'b1) begin bad++; $display("FAIL t6_in_data got=%b%b exp=11", o_grant, s_if.rready); end
    i_rst = 1'b1;
    ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h8000_0004;
    lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'ha000_0048;
    @(negedge clk); i_rst = 1'b0; s_if.rvalid = 1'b1; #1;
    total++; if ({s_if.arvalid, s_if.rready, ifu_if.rvalid, lsu_if.rvalid} !== 4'b0) begin bad++; $display("FAIL t6_after_rst got=%b exp=0000", {s_if.arvalid, s_if.rready, ifu_if.rvalid, lsu_if.rvalid}); end
    total++; if (o_grant !== 1'b0) begin bad++; $display("FAIL t6_grant got=%b exp=0", o_grant); end
    total++; if ({ifu_if.arready, lsu_if.arready} !== 2'b10) begin bad++; $display("FAIL t6_tie got=%b%b exp=10", ifu_if.arready, lsu_if.arready); end
    @(negedge clk); s_if.rvalid = 1'b0; ifu_if.arvalid = 1'b0; lsu_if.arvalid = 1'b0; #1;
    total++; if (s_if.araddr !== 32'h8000_0004 || o_grant !== 1'b0) begin bad++; $display("FAIL t6_ifu_first got=%h/%b exp=80000004/0", s_if.araddr, o_grant); end
  endtask

  initial begin
    test_reset;
    test_ifu_only;
    test_tie;
    test_back_to_back;
    test_stall;
    test_addr_hold;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
